mm_lsu: RTL and testbench

MM_LSU -- requirements
Module: mm_lsu

---
 rtl/mm_lsu.sv | 232 +++++++++++++++++++++++
 tb/tb_mm_lsu.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_lsu.sv
// rtl/mm_lsu.sv - MM-stage load/store unit: alignment check, lane steering, bus handshake with timeout
module mm_lsu #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [1:0]        mem_access_op,
    input  logic [2:0]        mem_access_sz,
    input  logic              flag_unsigned,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    input  logic [31:0]       reg_old_i,
    input  logic              exception_flush,
    output logic [ADDR_W-1:0] bus_address,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_byte_en,
    output logic              bus_rd,
    output logic              bus_wr,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic              stall_o,
    output logic [31:0]       data_o,
    output logic              data_valid_o,
    output logic              alignment_err,
    output logic              bus_err
);
    localparam logic [1:0] OP_M2R = 2'd0;
    localparam logic [1:0] OP_R2M = 2'd1;
    localparam logic [1:0] OP_D2R = 2'd2;

    localparam logic [2:0] SZ_WORD  = 3'd0;
    localparam logic [2:0] SZ_HALF  = 3'd1;
    localparam logic [2:0] SZ_BYTE  = 3'd2;
    localparam logic [2:0] SZ_LEFT  = 3'd3;
    localparam logic [2:0] SZ_RIGHT = 3'd4;

    // The counter value seen during the last permitted ACCESS cycle.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              rd_q;
    logic              wr_q;
    logic [2:0]        sz_q;
    logic [1:0]        lo_q;
    logic              unsigned_q;
    logic [31:0]       reg_old_q;
    logic [31:0]       load_q;
    logic [15:0]       cnt_q;

    logic [ADDR_W-1:0] addr_c;
    logic [31:0]       wdata_c;
    logic [3:0]        be_c;
    logic [31:0]       load_c;
    logic [31:0]       lane;
    logic [15:0]       half;
    logic [1:0]        a;
    logic              is_mem_op;
    logic              misaligned;
    logic              accept;
    logic              pass;
    logic              timeout_hit;

    assign a          = addr_i[1:0];
    assign addr_c     = {addr_i[ADDR_W-1:2], 2'b00};
    assign is_mem_op  = (mem_access_op == OP_M2R) || (mem_access_op == OP_R2M);
    assign misaligned = ((mem_access_sz == SZ_HALF) && a[0]) ||
                        ((mem_access_sz == SZ_WORD) && (a != 2'b00));
    assign accept     = (state_q == S_IDLE) && req_valid && is_mem_op &&
                        !misaligned && !exception_flush;
    assign pass       = (state_q == S_IDLE) && req_valid &&
                        (mem_access_op == OP_D2R) && !exception_flush;
    assign timeout_hit = (cnt_q == CNT_LAST);

    // Store-side lane steering; ~a equals 3-a on two bits.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = data_i;
        case (mem_access_sz)
            SZ_HALF: begin
                be_c    = {a[1], a[1], ~a[1], ~a[1]};
                wdata_c = {data_i[15:0], data_i[15:0]};
            end
            SZ_BYTE: begin
                be_c    = 4'b0001 << a;
                wdata_c = {4{data_i[7:0]}};
            end
            SZ_LEFT: begin
                be_c    = {a[1] & a[0], a[1], a[1] | a[0], 1'b1};
                wdata_c = data_i >> {~a, 3'b000};
            end
            SZ_RIGHT: begin
                be_c    = {1'b1, ~(a[1] & a[0]), ~a[1], ~(a[1] | a[0])};
                wdata_c = data_i << {a, 3'b000};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = data_i;
            end
        endcase
    end

    // Load-side alignment, extension and merge with the old register value.
    always_comb begin
        lane   = bus_rdata >> {lo_q, 3'b000};
        half   = lane[15:0];
        load_c = bus_rdata;
        case (sz_q)
            SZ_BYTE:  load_c = unsigned_q ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            SZ_HALF:  load_c = unsigned_q ? {16'b0, half} : {{16{half[15]}}, half};
            SZ_LEFT:  load_c = (bus_rdata << {~lo_q, 3'b000}) |
                               (reg_old_q & ~(32'hFFFF_FFFF << {~lo_q, 3'b000}));
            SZ_RIGHT: load_c = (bus_rdata >> {lo_q, 3'b000}) |
                               (reg_old_q & ~(32'hFFFF_FFFF >> {lo_q, 3'b000}));
            default:  load_c = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (exception_flush)  state_d = S_IDLE;
                else if (bus_ack)     state_d = S_DONE;
                else if (timeout_hit) state_d = S_IDLE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            sz_q       <= '0;
            lo_q       <= '0;
            unsigned_q <= 1'b0;
            reg_old_q  <= '0;
            load_q     <= '0;
            cnt_q      <= '0;
        end else if (accept) begin
            addr_q     <= addr_c;
            wdata_q    <= wdata_c;
            be_q       <= be_c;
            rd_q       <= (mem_access_op == OP_M2R);
            wr_q       <= (mem_access_op == OP_R2M);
            sz_q       <= mem_access_sz;
            lo_q       <= a;
            unsigned_q <= flag_unsigned;
            reg_old_q  <= reg_old_i;
            cnt_q      <= '0;
        end else if (state_q == S_ACCESS) begin
            cnt_q <= cnt_q + 16'd1;
            if (bus_ack && !exception_flush) load_q <= load_c;
        end
    end

    // Outputs are forced low while reset is asserted, independent of inputs.
    always_comb begin
        bus_address   = '0;
        bus_wdata     = '0;
        bus_byte_en   = '0;
        bus_rd        = 1'b0;
        bus_wr        = 1'b0;
        stall_o       = 1'b0;
        data_o        = '0;
        data_valid_o  = 1'b0;
        alignment_err = 1'b0;
        bus_err       = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        bus_address = addr_c;
                        bus_wdata   = wdata_c;
                        bus_byte_en = be_c;
                        bus_rd      = (mem_access_op == OP_M2R);
                        bus_wr      = (mem_access_op == OP_R2M);
                        stall_o     = 1'b1;
                    end
                    if (pass) begin
                        data_o       = data_i;
                        data_valid_o = 1'b1;
                    end
                    alignment_err = req_valid && is_mem_op && misaligned && !exception_flush;
                end
                S_ACCESS: begin
                    bus_address = addr_q;
                    bus_wdata   = wdata_q;
                    bus_byte_en = be_q;
                    bus_rd      = rd_q;
                    bus_wr      = wr_q;
                    stall_o     = 1'b1;
                    bus_err     = timeout_hit && !bus_ack && !exception_flush;
                end
                S_DONE: begin
                    if (rd_q && !exception_flush) begin
                        data_o       = load_q;
                        data_valid_o = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mm_lsu.sv
// tb/tb_mm_lsu.sv - directed bench for mm_lsu with a load-result scoreboard
module tb_mm_lsu;
    localparam logic [1:0] OP_M2R = 2'd0;
    localparam logic [1:0] OP_R2M = 2'd1;
    localparam logic [1:0] OP_D2R = 2'd2;
    localparam logic [2:0] SZ_WORD  = 3'd0;
    localparam logic [2:0] SZ_HALF  = 3'd1;
    localparam logic [2:0] SZ_BYTE  = 3'd2;
    localparam logic [2:0] SZ_LEFT  = 3'd3;
    localparam logic [2:0] SZ_RIGHT = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [1:0]  mem_access_op;
    logic [2:0]  mem_access_sz;
    logic        flag_unsigned;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] reg_old_i;
    logic        exception_flush;
    logic [31:0] bus_address;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byte_en;
    logic        bus_rd;
    logic        bus_wr;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stall_o;
    logic [31:0] data_o;
    logic        data_valid_o;
    logic        alignment_err;
    logic        bus_err;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mm_lsu #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .mem_access_op(mem_access_op), .mem_access_sz(mem_access_sz),
        .flag_unsigned(flag_unsigned), .addr_i(addr_i), .data_i(data_i),
        .reg_old_i(reg_old_i), .exception_flush(exception_flush),
        .bus_address(bus_address), .bus_wdata(bus_wdata), .bus_byte_en(bus_byte_en),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .stall_o(stall_o), .data_o(data_o), .data_valid_o(data_valid_o),
        .alignment_err(alignment_err), .bus_err(bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_sample(input string tag, input logic exp_v);
        check({tag, "_valid"}, {31'b0, data_valid_o}, {31'b0, exp_v});
        if (data_valid_o === 1'b1) begin
            if (exp_q.size() == 0) check({tag, "_orphan"}, 32'(exp_q.size()), 32'd1);
            else check({tag, "_data"}, data_o, exp_q.pop_front());
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic quiet();
        req_valid       = 1'b0;
        bus_ack         = 1'b0;
        exception_flush = 1'b0;
        bus_rdata       = 32'h0;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {31'b0, |{bus_address, bus_wdata, bus_byte_en, bus_rd, bus_wr, stall_o,
                             data_o, data_valid_o, alignment_err, bus_err}}, 32'd0);
    endtask

    task automatic do_load(input string tag, input logic [2:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] old,
                           input logic [31:0] rdata, input logic [3:0] be,
                           input logic [31:0] exp_data, input int w);
        int stalls;
        next_cycle();
        quiet();
        req_valid = 1'b1; mem_access_op = OP_M2R; mem_access_sz = sz;
        flag_unsigned = uns; addr_i = addr; reg_old_i = old; data_i = 32'h0;
        exp_q.push_back(exp_data);
        sample();
        stalls = int'(stall_o);
        check({tag, "_rd0"}, {31'b0, bus_rd}, 32'd1);
        check({tag, "_wr0"}, {31'b0, bus_wr}, 32'd0);
        check({tag, "_be0"}, {28'b0, bus_byte_en}, {28'b0, be});
        check({tag, "_adr0"}, bus_address, {addr[31:2], 2'b00});
        for (int c = 1; c <= w; c++) begin
            next_cycle();
            req_valid = 1'b0;
            bus_ack   = (c == w);
            bus_rdata = (c == w) ? rdata : 32'h0;
            sample();
            stalls += int'(stall_o);
            check($sformatf("%s_rd%0d", tag, c), {31'b0, bus_rd}, 32'd1);
            check($sformatf("%s_be%0d", tag, c), {28'b0, bus_byte_en}, {28'b0, be});
            sb_sample($sformatf("%s_acc%0d", tag, c), 1'b0);
        end
        next_cycle();
        quiet();
        sample();
        check({tag, "_stalls"}, 32'(stalls), 32'(w + 1));
        check({tag, "_stall_done"}, {31'b0, stall_o}, 32'd0);
        check({tag, "_rd_done"}, {31'b0, bus_rd}, 32'd0);
        sb_sample({tag, "_done"}, 1'b1);
        next_cycle();
        sample();
        sb_sample({tag, "_after"}, 1'b0);
    endtask

    task automatic do_store(input string tag, input logic [2:0] sz, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] be,
                            input logic [31:0] wdata);
        next_cycle();
        quiet();
        req_valid = 1'b1; mem_access_op = OP_R2M; mem_access_sz = sz;
        flag_unsigned = 1'b0; addr_i = addr; data_i = data;
        sample();
        check({tag, "_wr0"}, {31'b0, bus_wr}, 32'd1);
        check({tag, "_rd0"}, {31'b0, bus_rd}, 32'd0);
        check({tag, "_be0"}, {28'b0, bus_byte_en}, {28'b0, be});
        check({tag, "_wd0"}, bus_wdata, wdata);
        next_cycle();
        req_valid = 1'b0; data_i = 32'h5A5A_5A5A; bus_ack = 1'b1;
        sample();
        check({tag, "_wr1"}, {31'b0, bus_wr}, 32'd1);
        check({tag, "_wd1"}, bus_wdata, wdata);
        check({tag, "_be1"}, {28'b0, bus_byte_en}, {28'b0, be});
        next_cycle();
        quiet();
        sample();
        check({tag, "_wr_done"}, {31'b0, bus_wr}, 32'd0);
        check({tag, "_stall_done"}, {31'b0, stall_o}, 32'd0);
        sb_sample({tag, "_done"}, 1'b0);
    endtask

    task automatic do_timeout(input string tag, input logic ack_last);
        next_cycle();
        quiet();
        req_valid = 1'b1; mem_access_op = OP_M2R; mem_access_sz = SZ_WORD;
        flag_unsigned = 1'b0; addr_i = 32'h9000; reg_old_i = 32'h0;
        if (ack_last) exp_q.push_back(32'h0BAD_F00D);
        sample();
        check({tag, "_rd0"}, {31'b0, bus_rd}, 32'd1);
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            req_valid = 1'b0;
            bus_ack   = ack_last && (c == 4);
            bus_rdata = 32'h0BAD_F00D;
            sample();
            check($sformatf("%s_rd%0d", tag, c), {31'b0, bus_rd}, 32'd1);
            check($sformatf("%s_err%0d", tag, c), {31'b0, bus_err},
                  {31'b0, (c == 4) && !ack_last});
        end
        next_cycle();
        quiet();
        if (!ack_last) begin
            req_valid = 1'b1; mem_access_op = OP_D2R; data_i = 32'h7777_0001;
            exp_q.push_back(32'h7777_0001);
        end
        sample();
        check({tag, "_rd_after"}, {31'b0, bus_rd}, 32'd0);
        check({tag, "_err_after"}, {31'b0, bus_err}, 32'd0);
        check({tag, "_stall_after"}, {31'b0, stall_o}, 32'd0);
        sb_sample({tag, "_after"}, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        quiet();
        req_valid = 1'b1; mem_access_op = OP_M2R; mem_access_sz = SZ_WORD;
        flag_unsigned = 1'b0; addr_i = 32'h1234_5670; data_i = 32'hFFFF_FFFF;
        reg_old_i = 32'h0; bus_ack = 1'b1;
        sample();
        check_all_zero("reset_load_req");
        mem_access_op = OP_D2R;
        #1;
        check_all_zero("reset_d2r_req");
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        quiet();
        sample();
        check_all_zero("post_reset_idle");

        do_load("lb_0x1003", SZ_BYTE, 1'b0, 32'h1003, 32'h0, 32'h8011_2233, 4'b1000, 32'hFFFF_FF80, 2);
        do_load("lwl_0x2001", SZ_LEFT, 1'b0, 32'h2001, 32'hAABB_CCDD, 32'h1122_3344, 4'b0011, 32'h3344_CCDD, 1);
        do_load("lwl_0x2000", SZ_LEFT, 1'b0, 32'h2000, 32'hAABB_CCDD, 32'h1122_3344, 4'b0001, 32'h44BB_CCDD, 1);
        do_load("lwl_0x2003", SZ_LEFT, 1'b0, 32'h2003, 32'hAABB_CCDD, 32'h1122_3344, 4'b1111, 32'h1122_3344, 1);
        do_load("lwr_0x5002", SZ_RIGHT, 1'b0, 32'h5002, 32'hAABB_CCDD, 32'h1122_3344, 4'b1100, 32'hAABB_1122, 1);
        do_load("lwr_0x5003", SZ_RIGHT, 1'b0, 32'h5003, 32'hAABB_CCDD, 32'h1122_3344, 4'b1000, 32'hAABB_CC11, 3);
        do_load("lhu_0x6002", SZ_HALF, 1'b1, 32'h6002, 32'h0, 32'h8001_7FFF, 4'b1100, 32'h0000_8001, 1);
        do_load("lh_0x6000", SZ_HALF, 1'b0, 32'h6000, 32'h0, 32'h1234_8000, 4'b0011, 32'hFFFF_8000, 1);
        do_load("lbu_0x7001", SZ_BYTE, 1'b1, 32'h7001, 32'h0, 32'h0000_A500, 4'b0010, 32'h0000_00A5, 1);
        do_load("lw_0x8000", SZ_WORD, 1'b0, 32'h8000, 32'h0, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 2);

        do_store("sh_0x3002", SZ_HALF, 32'h3002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
        do_store("sb_0x3001", SZ_BYTE, 32'h3001, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
        do_store("swl_0x3001", SZ_LEFT, 32'h3001, 32'h1122_3344, 4'b0011, 32'h0000_1122);
        do_store("swr_0x3001", SZ_RIGHT, 32'h3001, 32'h1122_3344, 4'b1110, 32'h2233_4400);
        do_store("sw_0x3000", SZ_WORD, 32'h3000, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        next_cycle();
        quiet();
        req_valid = 1'b1; mem_access_op = OP_M2R; mem_access_sz = SZ_WORD; addr_i = 32'h4002;
        sample();
        check("lw_misal_err", {31'b0, alignment_err}, 32'd1);
        check("lw_misal_rd", {31'b0, bus_rd}, 32'd0);
        check("lw_misal_stall", {31'b0, stall_o}, 32'd0);
        next_cycle();
        mem_access_op = OP_D2R; data_i = 32'h1357_9BDF;
        exp_q.push_back(32'h1357_9BDF);
        sample();
        check("d2r_stall", {31'b0, stall_o}, 32'd0);
        check("d2r_err", {31'b0, alignment_err}, 32'd0);
        sb_sample("d2r", 1'b1);

        do_timeout("timeout", 1'b0);
        do_timeout("ack_at_limit", 1'b1);

        next_cycle();
        quiet();
        req_valid = 1'b1; mem_access_op = OP_M2R; mem_access_sz = SZ_WORD; addr_i = 32'hB000;
        sample();
        check("flush_rd0", {31'b0, bus_rd}, 32'd1);
        next_cycle();
        req_valid = 1'b0;
        sample();
        check("flush_rd1", {31'b0, bus_rd}, 32'd1);
        next_cycle();
        exception_flush = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
        sample();
        check("flush_cycle_err", {31'b0, bus_err}, 32'd0);
        sb_sample("flush_cycle", 1'b0);
        next_cycle();
        quiet();
        sample();
        check("flush_rd_after", {31'b0, bus_rd}, 32'd0);
        check("flush_stall_after", {31'b0, stall_o}, 32'd0);
        sb_sample("flush_after", 1'b0);
        next_cycle();
        sample();
        sb_sample("flush_after2", 1'b0);

        next_cycle();
        quiet();
        req_valid = 1'b1; mem_access_op = OP_R2M; mem_access_sz = SZ_WORD;
        addr_i = 32'hA000; data_i = 32'h1234_5678;
        sample();
        check("rst_wr0", {31'b0, bus_wr}, 32'd1);
        next_cycle();
        req_valid = 1'b0;
        sample();
        check("rst_wr1", {31'b0, bus_wr}, 32'd1);
        next_cycle();
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid_access");
        sample();
        check_all_zero("rst_hold");
        next_cycle();
        rst_n = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            sample();
            check($sformatf("rst_rel_wr%0d", c), {31'b0, bus_wr}, 32'd0);
            check($sformatf("rst_rel_stall%0d", c), {31'b0, stall_o}, 32'd0);
            sb_sample($sformatf("rst_rel%0d", c), 1'b0);
            next_cycle();
        end
        quiet();
        req_valid = 1'b1; mem_access_op = OP_D2R; data_i = 32'h0F0F_0F0F;
        exp_q.push_back(32'h0F0F_0F0F);
        sample();
        sb_sample("rst_rel_d2r", 1'b1);
        next_cycle();
        quiet();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
